// File: rtl/alu_divider_if.sv
// Operand/result bundle between the control unit and the sequential divider.
interface alu_divider_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/alu_divider.sv
// Sequential restoring divider: one quotient bit per clock, registered results
// with a divide-by-zero flag.
module alu_divider #(
  parameter int unsigned WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_divider_if.slave bus
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   shifted_c;
  logic [WIDTH:0]   trial_c;

  // Trial subtraction of the divisor from the shifted partial remainder
  assign shifted_c = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
  assign trial_c   = shifted_c - {1'b0, dvsr_q};

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvsr_d      = dvsr_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    done_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          dvsr_d = bus.divisor;
          quo_d  = bus.dividend;
          rem_d  = '0;
          dbz_d  = 1'b0;
          if (bus.divisor == '0) begin
            state_d     = DONE;
            done_d      = 1'b1;
            quotient_d  = '1;
            remainder_d = bus.dividend;
            dbz_d       = 1'b1;
          end else begin
            state_d = CALC;
            count_d = CW'(WIDTH - 1);
          end
        end
      end
      CALC: begin
        quo_d = {quo_q[WIDTH-2:0], ~trial_c[WIDTH]};
        rem_d = trial_c[WIDTH] ? shifted_c : trial_c;
        if (count_q == '0) begin
          state_d     = DONE;
          done_d      = 1'b1;
          quotient_d  = quo_d;
          remainder_d = rem_d[WIDTH-1:0];
        end else begin
          count_d = count_q - CW'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvsr_q      <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvsr_q      <= dvsr_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      dbz_q       <= dbz_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_divider.sv
// Self-checking bench for alu_divider: directed cases plus a random sweep
// against an arithmetic reference model.
module tb_alu_divider;

  localparam int unsigned W      = 8;
  localparam int          WINDOW = 14;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;

  alu_divider_if #(.WIDTH(W)) bus ();

  alu_divider #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Issue one division and watch WINDOW edges; optionally inject a second start
  // (50/5) that must be ignored, sampled at edge inj_edge.
  task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int inj_edge);
    int lat, done_cnt, done_at, busy_bad;
    logic [W-1:0] exp_q, exp_r, got_q, got_r;
    logic exp_z, got_z;
    exp_z = (b == 0);
    exp_q = exp_z ? {W{1'b1}} : W'(a / b);
    exp_r = exp_z ? a : W'(a % b);
    lat   = exp_z ? 1 : W + 1;
    done_cnt = 0; done_at = 0; busy_bad = 0;
    got_q = '0; got_r = '0; got_z = 1'b0;

    bus.dividend = a;
    bus.divisor  = b;
    bus.start    = 1'b1;
    @(posedge clk); #1;
    bus.start    = 1'b0;
    bus.dividend = W'($urandom);
    bus.divisor  = W'($urandom);

    for (int i = 1; i <= WINDOW; i++) begin
      if (bus.done === 1'b1) begin
        done_cnt++;
        if (done_cnt == 1) begin
          done_at = i;
          got_q = bus.quotient;
          got_r = bus.remainder;
          got_z = bus.div_by_zero;
        end
      end
      if (bus.busy !== (i <= lat)) busy_bad++;
      if (i == inj_edge - 1) begin
        bus.start = 1'b1; bus.dividend = 8'd50; bus.divisor = 8'd5;
      end else if (i == inj_edge) begin
        bus.start = 1'b0;
      end
      if (i < WINDOW) begin
        @(posedge clk); #1;
      end
    end

    chk({tag, " done_count"}, 32'(done_cnt), 32'd1);
    chk({tag, " done_edge"},  32'(done_at),  32'(lat));
    chk({tag, " busy_profile_errors"}, 32'(busy_bad), 32'd0);
    chk({tag, " quotient"},   32'(got_q), 32'(exp_q));
    chk({tag, " remainder"},  32'(got_r), 32'(exp_r));
    chk({tag, " div_by_zero"}, 32'(got_z), 32'(exp_z));
    chk({tag, " quotient_held"}, 32'(bus.quotient), 32'(exp_q));
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    int done_seen;

    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;

    // Reset release with idle inputs
    #23 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("reset busy",        32'(bus.busy),        32'd0);
    chk("reset done",        32'(bus.done),        32'd0);
    chk("reset quotient",    32'(bus.quotient),    32'd0);
    chk("reset remainder",   32'(bus.remainder),   32'd0);
    chk("reset div_by_zero", 32'(bus.div_by_zero), 32'd0);

    // Directed divisions
    run_div("200/7",  8'd200, 8'd7,  0);
    run_div("255/1",  8'd255, 8'd1,  0);
    run_div("3/10",   8'd3,   8'd10, 0);
    run_div("5/0",    8'd5,   8'd0,  0);
    run_div("12/4",   8'd12,  8'd4,  0);
    run_div("100/9 with start at edge 4", 8'd100, 8'd9, 4);

    // Reset between edges 4 and 5 of 200/7
    bus.dividend = 8'd200; bus.divisor = 8'd7; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset busy",      32'(bus.busy),      32'd0);
    chk("midreset done",      32'(bus.done),      32'd0);
    chk("midreset quotient",  32'(bus.quotient),  32'd0);
    chk("midreset remainder", 32'(bus.remainder), 32'd0);
    done_seen = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) done_seen++;
    end
    rst_n = 1'b1;
    repeat (8) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) done_seen++;
    end
    chk("midreset no done", 32'(done_seen), 32'd0);
    run_div("9/3 after reset", 8'd9, 8'd3, 0);

    // Random sweep with corner values mixed in
    for (int n = 0; n < 2000; n++) begin
      case ($urandom_range(0, 5))
        0:       ra = 8'd0;
        1:       ra = 8'd255;
        default: ra = W'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0:       rb = 8'd0;
        1:       rb = 8'd255;
        2:       rb = W'($urandom_range(1, 3));
        default: rb = W'($urandom);
      endcase
      run_div("random", ra, rb, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
